alu_flags: RTL

- Processor status (P) register stage directly downstream of the ALU.
- Takes a flag-update command issued in the same cycle as the ALU op.
- Delays it one cycle to line up with the ALU's registered result, then updates N V D I Z C.
- Also provides forwarded carry back to the ALU carry input, the push image for PHP/BRK/IRQ, and branch-condition evaluation.

---
 rtl/alu_flags_pkg.sv | 59 +++++
 rtl/alu_flags.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_flags_pkg.sv
// Shared definitions for the processor status (P) register stage:
// flag-command codes, P bit positions and the reset image.
package alu_flags_pkg;

  typedef enum logic [3:0] {
    FLG_NONE      = 4'h0,
    FLG_NZ        = 4'h1,
    FLG_NZC_SUM   = 4'h2,
    FLG_NZCV_SUM  = 4'h3,
    FLG_NZC_SHIFT = 4'h4,
    FLG_BIT       = 4'h5,
    FLG_PLP       = 4'h6,
    FLG_CLC       = 4'h7,
    FLG_SEC       = 4'h8,
    FLG_CLI       = 4'h9,
    FLG_SEI       = 4'hA,
    FLG_CLV       = 4'hB,
    FLG_CLD       = 4'hC,
    FLG_SED       = 4'hD,
    FLG_RSVD_E    = 4'hE,
    FLG_RSVD_F    = 4'hF
  } flg_op_t;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [7:0] P_RESET_DEFAULT = 8'h24;

  // Only the six flags that actually hold state; B and bit 5 are synthesised on output.
  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  function automatic logic [7:0] flags_to_p(input flags_t f, input logic b);
    logic [7:0] p;
    p      = 8'h00;
    p[P_N] = f.n;
    p[P_V] = f.v;
    p[P_U] = 1'b1;
    p[P_B] = b;
    p[P_D] = f.d;
    p[P_I] = f.i;
    p[P_Z] = f.z;
    p[P_C] = f.c;
    return p;
  endfunction

endpackage

// File: rtl/alu_flags.sv
// P register stage behind the ALU: delays the flag command one cycle to meet
// the registered ALU result, updates N V D I Z C, forwards carry, evaluates branches.
module alu_flags
  import alu_flags_pkg::*;
#(
  parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] flag_op_i,
  input  logic       shift_c_i,
  input  logic [7:0] alu_out_i,
  input  logic       sum_c_i,
  input  logic       sum_v_i,
  input  logic [7:0] data_i,
  input  logic       so_n_i,
  input  logic       brk_i,
  input  logic [1:0] br_sel_i,
  input  logic       br_val_i,
  output logic [7:0] p_o,
  output logic [7:0] p_push_o,
  output logic       carry_o,
  output logic       br_taken_o
);

  localparam flags_t FLAGS_RESET = '{
    n: P_RESET[P_N],
    v: P_RESET[P_V],
    d: P_RESET[P_D],
    i: P_RESET[P_I],
    z: P_RESET[P_Z],
    c: P_RESET[P_C]
  };

  flags_t  flags_q, flags_d;
  flg_op_t op_q, op_d;
  logic    sc_q, sc_d;
  logic    so_q, so_d;

  logic    z_res;
  logic    n_res;
  logic    so_fall;

  // PLP drops B and bit 5 of the pulled byte; BIT never looks at them either.
  logic    unused_data_bits;
  assign unused_data_bits = ^data_i[5:4];

  always_comb begin
    flags_d = flags_q;
    op_d    = flg_op_t'(flag_op_i);
    sc_d    = shift_c_i;
    so_d    = so_n_i;
    z_res   = (alu_out_i == 8'h00);
    n_res   = alu_out_i[7];
    so_fall = so_q & ~so_n_i;

    case (op_q)
      FLG_NZ: begin
        flags_d.n = n_res;
        flags_d.z = z_res;
      end
      FLG_NZC_SUM: begin
        flags_d.n = n_res;
        flags_d.z = z_res;
        flags_d.c = sum_c_i;
      end
      FLG_NZCV_SUM: begin
        flags_d.n = n_res;
        flags_d.z = z_res;
        flags_d.c = sum_c_i;
        flags_d.v = sum_v_i;
      end
      FLG_NZC_SHIFT: begin
        flags_d.n = n_res;
        flags_d.z = z_res;
        flags_d.c = sc_q;
      end
      FLG_BIT: begin
        flags_d.z = z_res;
        flags_d.n = data_i[7];
        flags_d.v = data_i[6];
      end
      FLG_PLP: begin
        flags_d.n = data_i[P_N];
        flags_d.v = data_i[P_V];
        flags_d.d = data_i[P_D];
        flags_d.i = data_i[P_I];
        flags_d.z = data_i[P_Z];
        flags_d.c = data_i[P_C];
      end
      FLG_CLC: flags_d.c = 1'b0;
      FLG_SEC: flags_d.c = 1'b1;
      FLG_CLI: flags_d.i = 1'b0;
      FLG_SEI: flags_d.i = 1'b1;
      FLG_CLV: flags_d.v = 1'b0;
      FLG_CLD: flags_d.d = 1'b0;
      FLG_SED: flags_d.d = 1'b1;
      default: ;
    endcase

    // The SO pin edge takes priority over any V written by the command in flight.
    if (so_fall) begin
      flags_d.v = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= FLAGS_RESET;
      op_q    <= FLG_NONE;
      sc_q    <= 1'b0;
      so_q    <= 1'b1;
    end else begin
      flags_q <= flags_d;
      op_q    <= op_d;
      sc_q    <= sc_d;
      so_q    <= so_d;
    end
  end

  // Carry is forwarded from the next-state value so back-to-back ADC/SBC chain correctly.
  assign carry_o  = flags_d.c;
  assign p_o      = flags_to_p(flags_q, 1'b0);
  assign p_push_o = flags_to_p(flags_q, brk_i);

  always_comb begin
    br_taken_o = 1'b0;
    case (br_sel_i)
      2'd0:    br_taken_o = (flags_q.n == br_val_i);
      2'd1:    br_taken_o = (flags_q.v == br_val_i);
      2'd2:    br_taken_o = (flags_q.c == br_val_i);
      default: br_taken_o = (flags_q.z == br_val_i);
    endcase
  end

endmodule
